// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - two-road intersection lamp controller with night blink mode; optional pedestrian request via PED_REQ_EN
module traffic_ctrl #(
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 2,
    parameter int T_LEFT   = 10,
    parameter int T_WALK   = 14,
    parameter int T_BLINK  = 4,
    parameter int CNT_W    = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       night_mode,
`ifdef PED_REQ_EN
    input  logic       ped_req,
`endif
    output logic [2:0] h_car_traffic,
    output logic [2:0] h_walker_traffic,
    output logic [2:0] v_car_traffic,
    output logic [2:0] v_walker_traffic,
    output logic [3:0] phase
);

    // Lamp codes shared by car and walker heads
    localparam logic [2:0] L_RED     = 3'b000;
    localparam logic [2:0] L_GREEN   = 3'b001;
    localparam logic [2:0] L_YELLOW  = 3'b010;
    localparam logic [2:0] L_LEFT    = 3'b011;
    localparam logic [2:0] L_TWINKLE = 3'b100;

    // Timer reload values: each state lasts exactly its duration
    localparam logic [CNT_W-1:0] L_LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] L_LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] L_LD_LEFT   = CNT_W'(T_LEFT - 1);
    localparam logic [CNT_W-1:0] L_LD_BLINK  = CNT_W'(T_BLINK - 1);
    localparam logic [CNT_W-1:0] L_ONE       = CNT_W'(1);
    // Walker stays solid green while timer is at or above this threshold
    localparam logic [CNT_W-1:0] L_WALK_TH   = CNT_W'(T_GREEN - T_WALK);

    typedef enum logic [3:0] {
        S_H_GREEN = 4'd0,
        S_H_YEL1  = 4'd1,
        S_H_LEFT  = 4'd2,
        S_H_YEL2  = 4'd3,
        S_V_GREEN = 4'd4,
        S_V_YEL1  = 4'd5,
        S_V_LEFT  = 4'd6,
        S_V_YEL2  = 4'd7,
        S_NIGHT   = 4'd8
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_timer;
    logic             r_blink;

    logic             w_timer_zero;
    logic             w_walk_solid;
    logic             w_serve_h;
    logic             w_serve_v;

    assign w_timer_zero = (r_timer == '0);
    assign w_walk_solid = (r_timer >= L_WALK_TH);

    // Phase sequencer: state, phase timer and night blink toggle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_H_GREEN;
            r_timer <= L_LD_GREEN;
            r_blink <= 1'b0;
        end else begin
            r_timer <= r_timer - L_ONE;
            case (r_state)
                S_H_GREEN: begin
                    if (w_timer_zero) begin
                        r_state <= S_H_YEL1;
                        r_timer <= L_LD_YELLOW;
                    end
                end
                S_H_YEL1: begin
                    if (w_timer_zero) begin
                        r_state <= S_H_LEFT;
                        r_timer <= L_LD_LEFT;
                    end
                end
                S_H_LEFT: begin
                    if (w_timer_zero) begin
                        r_state <= S_H_YEL2;
                        r_timer <= L_LD_YELLOW;
                    end
                end
                S_H_YEL2: begin
                    if (w_timer_zero) begin
                        if (night_mode) begin
                            r_state <= S_NIGHT;
                            r_timer <= L_LD_BLINK;
                            r_blink <= 1'b1;
                        end else begin
                            r_state <= S_V_GREEN;
                            r_timer <= L_LD_GREEN;
                        end
                    end
                end
                S_V_GREEN: begin
                    if (w_timer_zero) begin
                        r_state <= S_V_YEL1;
                        r_timer <= L_LD_YELLOW;
                    end
                end
                S_V_YEL1: begin
                    if (w_timer_zero) begin
                        r_state <= S_V_LEFT;
                        r_timer <= L_LD_LEFT;
                    end
                end
                S_V_LEFT: begin
                    if (w_timer_zero) begin
                        r_state <= S_V_YEL2;
                        r_timer <= L_LD_YELLOW;
                    end
                end
                S_V_YEL2: begin
                    if (w_timer_zero) begin
                        if (night_mode) begin
                            r_state <= S_NIGHT;
                            r_timer <= L_LD_BLINK;
                            r_blink <= 1'b1;
                        end else begin
                            r_state <= S_H_GREEN;
                            r_timer <= L_LD_GREEN;
                        end
                    end
                end
                S_NIGHT: begin
                    // Leaving night wins over a coincident blink toggle
                    if (!night_mode) begin
                        r_state <= S_H_GREEN;
                        r_timer <= L_LD_GREEN;
                        r_blink <= 1'b0;
                    end else if (w_timer_zero) begin
                        r_timer <= L_LD_BLINK;
                        r_blink <= ~r_blink;
                    end
                end
                default: begin
                    r_state <= S_H_GREEN;
                    r_timer <= L_LD_GREEN;
                    r_blink <= 1'b0;
                end
            endcase
        end
    end

`ifdef PED_REQ_EN
    logic r_flag_h;
    logic r_flag_v;
    logic r_serve_h;
    logic r_serve_v;
    logic w_enter_h_green;
    logic w_enter_v_green;

    // H_GREEN serves the vertical walker, V_GREEN the horizontal one
    assign w_enter_v_green = (r_state == S_H_YEL2) && w_timer_zero && !night_mode;
    assign w_enter_h_green = ((r_state == S_V_YEL2) && w_timer_zero && !night_mode) ||
                             ((r_state == S_NIGHT) && !night_mode) ||
                             (r_state > S_NIGHT);

    // Request latches; the serve bit is frozen at green entry for that phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flag_h  <= 1'b0;
            r_flag_v  <= 1'b0;
            r_serve_h <= 1'b0;
            r_serve_v <= 1'b0;
        end else begin
            if (w_enter_h_green) begin
                r_serve_v <= r_flag_v | ped_req;
                r_flag_v  <= 1'b0;
            end else if (ped_req) begin
                r_flag_v  <= 1'b1;
            end
            if (w_enter_v_green) begin
                r_serve_h <= r_flag_h | ped_req;
                r_flag_h  <= 1'b0;
            end else if (ped_req) begin
                r_flag_h  <= 1'b1;
            end
        end
    end

    assign w_serve_h = r_serve_h;
    assign w_serve_v = r_serve_v;
`else
    assign w_serve_h = 1'b1;
    assign w_serve_v = 1'b1;
`endif

    // Moore lamp decode from state, timer and blink registers only
    always_comb begin
        h_car_traffic    = L_RED;
        h_walker_traffic = L_RED;
        v_car_traffic    = L_RED;
        v_walker_traffic = L_RED;
        case (r_state)
            S_H_GREEN: begin
                h_car_traffic = L_GREEN;
                if (w_serve_v) begin
                    v_walker_traffic = w_walk_solid ? L_GREEN : L_TWINKLE;
                end
            end
            S_H_YEL1: h_car_traffic = L_YELLOW;
            S_H_LEFT: h_car_traffic = L_LEFT;
            S_H_YEL2: h_car_traffic = L_YELLOW;
            S_V_GREEN: begin
                v_car_traffic = L_GREEN;
                if (w_serve_h) begin
                    h_walker_traffic = w_walk_solid ? L_GREEN : L_TWINKLE;
                end
            end
            S_V_YEL1: v_car_traffic = L_YELLOW;
            S_V_LEFT: v_car_traffic = L_LEFT;
            S_V_YEL2: v_car_traffic = L_YELLOW;
            S_NIGHT: begin
                h_car_traffic = r_blink ? L_YELLOW : L_RED;
                v_car_traffic = r_blink ? L_YELLOW : L_RED;
            end
            default: begin
                h_car_traffic = L_RED;
                v_car_traffic = L_RED;
            end
        endcase
    end

    assign phase = r_state;

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb/tb_traffic_ctrl.sv - scoreboard bench for traffic_ctrl (default and short-timing instances)
module tb_traffic_ctrl;

    localparam logic [2:0] R = 3'd0;
    localparam logic [2:0] G = 3'd1;
    localparam logic [2:0] Y = 3'd2;
    localparam logic [2:0] L = 3'd3;
    localparam logic [2:0] T = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst2;
    logic       night_mode;
`ifdef PED_REQ_EN
    logic       ped_req = 1'b0;
`endif
    logic [2:0] h_car, h_walk, v_car, v_walk;
    logic [3:0] phase;
    logic [2:0] s_h_car, s_h_walk, s_v_car, s_v_walk;
    logic [3:0] s_phase;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] hc;
        logic [2:0] hw;
        logic [2:0] vc;
        logic [2:0] vw;
        logic [3:0] ph;
        int         tag;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    traffic_ctrl u_dut (
        .clk              (clk),
        .rst              (rst),
        .night_mode       (night_mode),
`ifdef PED_REQ_EN
        .ped_req          (ped_req),
`endif
        .h_car_traffic    (h_car),
        .h_walker_traffic (h_walk),
        .v_car_traffic    (v_car),
        .v_walker_traffic (v_walk),
        .phase            (phase)
    );

    traffic_ctrl #(
        .T_GREEN  (6),
        .T_YELLOW (1),
        .T_LEFT   (3),
        .T_WALK   (4)
    ) u_small (
        .clk              (clk),
        .rst              (rst2),
        .night_mode       (night_mode),
`ifdef PED_REQ_EN
        .ped_req          (ped_req),
`endif
        .h_car_traffic    (s_h_car),
        .h_walker_traffic (s_h_walk),
        .v_car_traffic    (s_v_car),
        .v_walker_traffic (s_v_walk),
        .phase            (s_phase)
    );

    function automatic exp_t mk(logic [2:0] hc, logic [2:0] hw, logic [2:0] vc,
                                logic [2:0] vw, logic [3:0] ph, int tag);
        exp_t e;
        e.hc = hc; e.hw = hw; e.vc = vc; e.vw = vw; e.ph = ph; e.tag = tag;
        return e;
    endfunction

    // Hand-computed 68-cycle default sequence
    function automatic exp_t exp_def(int c, int tag);
        if (c < 14)      return mk(G, R, R, G, 4'd0, tag);
        else if (c < 20) return mk(G, R, R, T, 4'd0, tag);
        else if (c < 22) return mk(Y, R, R, R, 4'd1, tag);
        else if (c < 32) return mk(L, R, R, R, 4'd2, tag);
        else if (c < 34) return mk(Y, R, R, R, 4'd3, tag);
        else if (c < 48) return mk(R, G, G, R, 4'd4, tag);
        else if (c < 54) return mk(R, T, G, R, 4'd4, tag);
        else if (c < 56) return mk(R, R, Y, R, 4'd5, tag);
        else if (c < 66) return mk(R, R, L, R, 4'd6, tag);
        else             return mk(R, R, Y, R, 4'd7, tag);
    endfunction

    // Hand-computed 22-cycle sequence for green 6, yellow 1, left 3, walk 4
    function automatic exp_t exp_small(int c, int tag);
        if (c < 4)        return mk(G, R, R, G, 4'd0, tag);
        else if (c < 6)   return mk(G, R, R, T, 4'd0, tag);
        else if (c == 6)  return mk(Y, R, R, R, 4'd1, tag);
        else if (c < 10)  return mk(L, R, R, R, 4'd2, tag);
        else if (c == 10) return mk(Y, R, R, R, 4'd3, tag);
        else if (c < 15)  return mk(R, G, G, R, 4'd4, tag);
        else if (c < 17)  return mk(R, T, G, R, 4'd4, tag);
        else if (c == 17) return mk(R, R, Y, R, 4'd5, tag);
        else if (c < 21)  return mk(R, R, L, R, 4'd6, tag);
        else              return mk(R, R, Y, R, 4'd7, tag);
    endfunction

    // Night: k cycles after entry; yellow for 4, red for 4, repeating
    function automatic exp_t exp_night(int k, int tag);
        if (((k / 4) % 2) == 0) return mk(Y, R, Y, R, 4'd8, tag);
        else                    return mk(R, R, R, R, 4'd8, tag);
    endfunction

    task automatic check(string nm, exp_t e, logic [2:0] hc, logic [2:0] hw,
                         logic [2:0] vc, logic [2:0] vw, logic [3:0] ph);
        n_cmp++;
        if ({hc, hw, vc, vw, ph} !== {e.hc, e.hw, e.vc, e.vw, e.ph}) begin
            n_err++;
            $display("FAIL %s tag=%0d got hc=%0d hw=%0d vc=%0d vw=%0d ph=%0d want hc=%0d hw=%0d vc=%0d vw=%0d ph=%0d",
                     nm, e.tag, hc, hw, vc, vw, ph, e.hc, e.hw, e.vc, e.vw, e.ph);
        end
    endtask

    // Monitor: pops one expectation per queue per cycle, mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("main", e, h_car, h_walk, v_car, v_walk, phase);
        end
        if (q2.size() > 0) begin
            e = q2.pop_front();
            check("short", e, s_h_car, s_h_walk, s_v_car, s_v_walk, s_phase);
        end
    end

    initial begin
        rst        = 1'b1;
        rst2       = 1'b1;
        night_mode = 1'b0;

        // Reset state, then one full cycle; night pulses that drop before YEL2 expiry
        @(posedge clk); #1;
        rst = 1'b0;
        q1.push_back(exp_def(0, 1000));
        for (int c = 1; c <= 68; c++) begin
            @(posedge clk); #1;
            if (c == 25) night_mode = 1'b1;
            if (c == 33) night_mode = 1'b0;
            if (c == 60) night_mode = 1'b1;
            if (c == 67) night_mode = 1'b0;
            q1.push_back(exp_def(c % 68, 1000 + c));
        end

        // Night request at cycle 5 takes effect after H_YEL2, then exit
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (c == 5) night_mode = 1'b1;
            if (c < 34) q1.push_back(exp_def(c, 3000 + c));
            else        q1.push_back(exp_night(c - 34, 3000 + c));
            if (c == 45) night_mode = 1'b0;
        end
        for (int c = 46; c <= 66; c++) begin
            @(posedge clk); #1;
            q1.push_back(exp_def(c - 46, 3000 + c));
        end

        // Run into V_LEFT, then assert reset between clock edges
        for (int i = 21; i <= 60; i++) begin
            @(posedge clk); #1;
            q1.push_back(exp_def(i, 4000 + i));
        end
        @(posedge clk); #2;
        rst = 1'b1;
        q1.push_back(exp_def(0, 4100));
        @(posedge clk); #1;
        rst = 1'b0;
        q1.push_back(exp_def(0, 4200));
        for (int c = 1; c <= 68; c++) begin
            @(posedge clk); #1;
            q1.push_back(exp_def(c % 68, 4200 + c));
        end

        // Short-timing instance: 22-cycle loop plus wrap
        @(posedge clk); #1;
        rst2 = 1'b0;
        q2.push_back(exp_small(0, 5000));
        for (int c = 1; c <= 22; c++) begin
            @(posedge clk); #1;
            q2.push_back(exp_small(c % 22, 5000 + c));
        end

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (q1.size() + q2.size() != 0) begin
            n_err++;
            $display("FAIL drain left=%0d want 0", q1.size() + q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
